// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder: packs field bundles into 32-bit words and
// writes them to sequential instruction-memory addresses over a valid/ready port.
module instr_encoder #(
    parameter int ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    input  logic                  i_Start,
    input  logic                  i_Valid,
    output logic                  o_Ready,
    input  logic                  i_Last,
    input  logic [6:0]            i_OpCode,
    input  logic [4:0]            i_Rd,
    input  logic [4:0]            i_Rs1,
    input  logic [4:0]            i_Rs2,
    input  logic [2:0]            i_Funct3,
    input  logic [6:0]            i_Funct7,
    input  logic [31:0]           i_Imm,
    output logic                  o_WrValid,
    input  logic                  i_WrReady,
    output logic [ADDR_WIDTH-1:0] o_WrAddr,
    output logic [31:0]           o_WrData,
    output logic                  o_Done,
    output logic                  o_Error
);

    localparam logic [6:0] OP_LW    = 7'd3;
    localparam logic [6:0] OP_ITYPE = 7'd19;
    localparam logic [6:0] OP_SW    = 7'd35;
    localparam logic [6:0] OP_RTYPE = 7'd51;
    localparam logic [6:0] OP_BEQ   = 7'd99;
    localparam logic [6:0] OP_JAL   = 7'd111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   next_addr;
    logic                    accept;
    logic                    handshake;
    logic                    legal;
    logic [31:0]             encoded;
    logic                    fits_12;
    logic                    fits_13;
    logic                    fits_21;

    assign o_Ready   = (state == RUN) && (!o_WrValid || i_WrReady);
    assign accept    = i_Valid && o_Ready;
    assign handshake = o_WrValid && i_WrReady;

    // A value fits an N-bit signed field when all bits from N-1 upward are copies of the sign.
    assign fits_12 = (&i_Imm[31:11]) || !(|i_Imm[31:11]);
    assign fits_13 = (&i_Imm[31:12]) || !(|i_Imm[31:12]);
    assign fits_21 = (&i_Imm[31:20]) || !(|i_Imm[31:20]);

    always_comb begin
        legal = 1'b0;
        case (i_OpCode)
            OP_LW, OP_ITYPE, OP_SW: legal = fits_12;
            OP_RTYPE:               legal = 1'b1;
            OP_BEQ:                 legal = fits_13 && !i_Imm[0];
            OP_JAL:                 legal = fits_21 && !i_Imm[0];
            default:                legal = 1'b0;
        endcase
    end

    always_comb begin
        encoded = 32'd0;
        case (i_OpCode)
            OP_LW, OP_ITYPE:
                encoded = {i_Imm[11:0], i_Rs1, i_Funct3, i_Rd, i_OpCode};
            OP_SW:
                encoded = {i_Imm[11:5], i_Rs2, i_Rs1, i_Funct3, i_Imm[4:0], i_OpCode};
            OP_RTYPE:
                encoded = {i_Funct7, i_Rs2, i_Rs1, i_Funct3, i_Rd, i_OpCode};
            OP_BEQ:
                encoded = {i_Imm[12], i_Imm[10:5], i_Rs2, i_Rs1, i_Funct3,
                           i_Imm[4:1], i_Imm[11], i_OpCode};
            OP_JAL:
                encoded = {i_Imm[20], i_Imm[10:1], i_Imm[11], i_Imm[19:12], i_Rd, i_OpCode};
            default:
                encoded = 32'd0;
        endcase
    end

    // Later assignments override earlier ones, so a same-cycle accept reloads the
    // output register right after the handshake has emptied it.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state     <= IDLE;
            next_addr <= BASE_ADDR;
            o_WrValid <= 1'b0;
            o_WrAddr  <= BASE_ADDR;
            o_WrData  <= 32'd0;
            o_Done    <= 1'b0;
            o_Error   <= 1'b0;
        end else begin
            o_Done <= 1'b0;

            if (handshake) begin
                o_WrValid <= 1'b0;
            end

            if (accept) begin
                if (legal) begin
                    o_WrValid <= 1'b1;
                    o_WrData  <= encoded;
                    o_WrAddr  <= next_addr;
                    next_addr <= next_addr + ADDR_WIDTH'(4);
                end else begin
                    o_Error <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (i_Start) begin
                        state     <= RUN;
                        next_addr <= BASE_ADDR;
                        o_Error   <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept && i_Last) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (!o_WrValid || handshake) begin
                        state  <= IDLE;
                        o_Done <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed format/backpressure/illegal/reset/wrap
// scenarios plus randomized streams scored against a field-level reference model.
`timescale 1ns/1ps
module tb_instr_encoder;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        i_Clk = 1'b0;
    logic        i_Reset = 1'b1;
    logic        i_Start = 1'b0;
    logic        i_Valid = 1'b0;
    logic        i_Last = 1'b0;
    logic [6:0]  i_OpCode = '0;
    logic [4:0]  i_Rd = '0;
    logic [4:0]  i_Rs1 = '0;
    logic [4:0]  i_Rs2 = '0;
    logic [2:0]  i_Funct3 = '0;
    logic [6:0]  i_Funct7 = '0;
    logic [31:0] i_Imm = '0;
    logic        i_WrReady = 1'b1;

    logic        o_Ready, o_WrValid, o_Done, o_Error;
    logic [31:0] o_WrAddr, o_WrData;
    logic        o2_Ready, o2_WrValid, o2_Done, o2_Error;
    logic [31:0] o2_WrAddr, o2_WrData;

    int n_cmp = 0;
    int n_fail = 0;

    bit   rand_ready = 1'b0;
    logic ready_force = 1'b1;

    wr_t got_q[$];
    wr_t got2_q[$];
    wr_t exp_q[$];
    logic [31:0] model_addr = '0;
    bit          model_err = 1'b0;

    instr_encoder #(.ADDR_WIDTH(32), .BASE_ADDR(32'h0000_0000)) dut (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Start(i_Start), .i_Valid(i_Valid),
        .o_Ready(o_Ready), .i_Last(i_Last), .i_OpCode(i_OpCode), .i_Rd(i_Rd),
        .i_Rs1(i_Rs1), .i_Rs2(i_Rs2), .i_Funct3(i_Funct3), .i_Funct7(i_Funct7),
        .i_Imm(i_Imm), .o_WrValid(o_WrValid), .i_WrReady(i_WrReady),
        .o_WrAddr(o_WrAddr), .o_WrData(o_WrData), .o_Done(o_Done), .o_Error(o_Error)
    );

    instr_encoder #(.ADDR_WIDTH(32), .BASE_ADDR(32'hFFFF_FFFC)) dut_wrap (
        .i_Clk(i_Clk), .i_Reset(i_Reset), .i_Start(i_Start), .i_Valid(i_Valid),
        .o_Ready(o2_Ready), .i_Last(i_Last), .i_OpCode(i_OpCode), .i_Rd(i_Rd),
        .i_Rs1(i_Rs1), .i_Rs2(i_Rs2), .i_Funct3(i_Funct3), .i_Funct7(i_Funct7),
        .i_Imm(i_Imm), .o_WrValid(o2_WrValid), .i_WrReady(i_WrReady),
        .o_WrAddr(o2_WrAddr), .o_WrData(o2_WrData), .o_Done(o2_Done), .o_Error(o2_Error)
    );

    always #5 i_Clk = ~i_Clk;

    always @(posedge i_Clk) begin
        #1;
        i_WrReady = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end

    // Completed write handshakes, sampled mid-cycle; a reset cycle never counts.
    always @(negedge i_Clk) begin
        if (!i_Reset && o_WrValid === 1'b1 && i_WrReady === 1'b1)
            got_q.push_back({o_WrAddr, o_WrData});
        if (!i_Reset && o2_WrValid === 1'b1 && i_WrReady === 1'b1)
            got2_q.push_back({o2_WrAddr, o2_WrData});
    end

    function automatic bit ref_legal(input int op, input int imm);
        case (op)
            3, 19, 35: return (imm >= -2048) && (imm <= 2047);
            51:        return 1'b1;
            99:        return (imm % 2 == 0) && (imm >= -4096) && (imm <= 4094);
            111:       return (imm % 2 == 0) && (imm >= -1048576) && (imm <= 1048574);
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] field(input int v, input int hi, input int lo);
        logic [31:0] u;
        u = v;
        return (u >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
    endfunction

    function automatic logic [31:0] ref_encode(input int op, input int rd, input int rs1,
                                               input int rs2, input int f3, input int f7,
                                               input int imm);
        logic [31:0] base;
        base = 32'(op) | (32'(rs1) << 15) | (32'(f3) << 12);
        case (op)
            3, 19: return base | (field(imm, 11, 0) << 20) | (32'(rd) << 7);
            35:    return base | (field(imm, 11, 5) << 25) | (32'(rs2) << 20)
                               | (field(imm, 4, 0) << 7);
            51:    return base | (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rd) << 7);
            99:    return base | (field(imm, 12, 12) << 31) | (field(imm, 10, 5) << 25)
                               | (32'(rs2) << 20) | (field(imm, 4, 1) << 8)
                               | (field(imm, 11, 11) << 7);
            111:   return 32'(op) | (field(imm, 20, 20) << 31) | (field(imm, 10, 1) << 21)
                               | (field(imm, 11, 11) << 20) | (field(imm, 19, 12) << 12)
                               | (32'(rd) << 7);
            default: return 32'd0;
        endcase
    endfunction

    function automatic int pick_imm(input int op);
        int lo, hi;
        lo = -2048;
        hi = 2047;
        if (op == 99) begin lo = -4096; hi = 4094; end
        if (op == 111) begin lo = -1048576; hi = 1048574; end
        case ($urandom_range(0, 6))
            0: return lo;
            1: return hi;
            2: return lo - 1;
            3: return hi + 1;
            4: return lo + 1;
            default: return (lo + int'($urandom_range(0, hi - lo))) & ~((op == 99 || op == 111) ? 1 : 0);
        endcase
    endfunction

    // Present one bundle and hold it until accepted; the model consumes it on acceptance.
    task automatic send(input int op, input int rd, input int rs1, input int rs2,
                        input int f3, input int f7, input int imm, input bit last,
                        output int waits);
        bit taken;
        i_Valid = 1'b1;
        i_OpCode = 7'(op);
        i_Rd = 5'(rd);
        i_Rs1 = 5'(rs1);
        i_Rs2 = 5'(rs2);
        i_Funct3 = 3'(f3);
        i_Funct7 = 7'(f7);
        i_Imm = 32'(imm);
        i_Last = last;
        waits = 0;
        taken = 1'b0;
        while (!taken && waits <= 200) begin
            @(negedge i_Clk);
            if (o_Ready === 1'b1) taken = 1'b1;
            else waits++;
        end
        if (!taken) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL accept_timeout: o_Ready stayed %b, required 1", o_Ready);
        end else if (ref_legal(op, imm)) begin
            exp_q.push_back({model_addr, ref_encode(op, rd, rs1, rs2, f3, f7, imm)});
            model_addr += 32'd4;
        end else begin
            model_err = 1'b1;
        end
        @(posedge i_Clk);
        #1;
    endtask

    task automatic start_stream();
        @(posedge i_Clk);
        #1 i_Start = 1'b1;
        @(posedge i_Clk);
        #1 i_Start = 1'b0;
        model_addr = 32'd0;
        model_err = 1'b0;
        exp_q.delete();
        got_q.delete();
        got2_q.delete();
    endtask

    task automatic wait_done(output bit found, output int cycles);
        found = 1'b0;
        cycles = 0;
        for (int i = 0; i < 300 && !found; i++) begin
            @(negedge i_Clk);
            if (o_Done === 1'b1) begin
                found = 1'b1;
                cycles = i;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge i_Clk);
        @(negedge i_Clk);
        n_cmp++;
        if ({o_Ready, o_WrValid, o_Done, o_Error} !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_flags: got %b, required 0000", {o_Ready, o_WrValid, o_Done, o_Error});
        end
        n_cmp++;
        if (o_WrAddr !== 32'd0 || o_WrData !== 32'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_regs: addr %h data %h, required 0 0", o_WrAddr, o_WrData);
        end
        n_cmp++;
        if (o2_WrAddr !== 32'hFFFF_FFFC) begin
            n_fail++;
            $display("[TB] FAIL reset_base: addr %h, required fffffffc", o2_WrAddr);
        end
        @(posedge i_Clk);
        #1 i_Reset = 1'b0;
    endtask

    task automatic test_addi();
        int w, cyc;
        bit found;
        start_stream();
        send(19, 1, 0, 0, 0, 0, 5, 1'b1, w);
        i_Valid = 1'b0;
        wait_done(found, cyc);
        n_cmp++;
        if (!found || cyc != 1) begin
            n_fail++;
            $display("[TB] FAIL addi_done: found %0d after %0d, required found after 1", found, cyc);
        end
        n_cmp++;
        if (got_q.size() != 1 || got_q[0] !== {32'h0, 32'h0050_0093}) begin
            n_fail++;
            $display("[TB] FAIL addi_word: %0d writes, first %h, required 1 write 0000000000500093",
                     got_q.size(), got_q.size() > 0 ? got_q[0] : 64'h0);
        end
        @(negedge i_Clk);
        n_cmp++;
        if (o_Done !== 1'b0 || o_Ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL addi_idle: done %b ready %b, required 0 0", o_Done, o_Ready);
        end
    endtask

    task automatic test_formats();
        int w, cyc;
        bit found;
        wr_t want[3];
        want[0] = {32'h0, 32'h0020_2423};
        want[1] = {32'h4, 32'hFE00_0EE3};
        want[2] = {32'h8, 32'h0010_00EF};
        start_stream();
        send(35, 0, 0, 2, 2, 0, 8, 1'b0, w);
        send(99, 0, 0, 0, 0, 0, -4, 1'b0, w);
        send(111, 1, 0, 0, 0, 0, 2048, 1'b1, w);
        i_Valid = 1'b0;
        wait_done(found, cyc);
        n_cmp++;
        if (got_q.size() != 3 || !found) begin
            n_fail++;
            $display("[TB] FAIL formats_count: %0d writes done %0d, required 3 and done", got_q.size(), found);
        end
        for (int i = 0; i < 3 && i < got_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== want[i]) begin
                n_fail++;
                $display("[TB] FAIL formats_word%0d: got %h, required %h", i, got_q[i], want[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int w, cyc;
        bit found;
        ready_force = 1'b0;
        @(posedge i_Clk);
        #2;
        start_stream();
        send(19, 5, 6, 0, 0, 0, -7, 1'b0, w);
        i_OpCode = 7'd35; i_Rs1 = 5'd3; i_Rs2 = 5'd4; i_Funct3 = 3'd2; i_Imm = 32'd100;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_Clk);
            n_cmp++;
            if (o_Ready !== 1'b0 || o_WrValid !== 1'b1 || {o_WrAddr, o_WrData} !== exp_q[0]) begin
                n_fail++;
                $display("[TB] FAIL stall_cycle%0d: ready %b valid %b word %h, required 0 1 %h",
                         i, o_Ready, o_WrValid, {o_WrAddr, o_WrData}, exp_q[0]);
            end
        end
        ready_force = 1'b1;
        send(35, 0, 3, 4, 2, 0, 100, 1'b0, w);
        for (int k = 0; k < 4; k++) begin
            send(19, $urandom_range(0, 31), $urandom_range(0, 31), 0, $urandom_range(0, 7), 0,
                 int'($urandom_range(0, 4095)) - 2048, k == 3, w);
            n_cmp++;
            if (w != 0) begin
                n_fail++;
                $display("[TB] FAIL b2b_wait%0d: waited %0d cycles, required 0", k, w);
            end
        end
        i_Valid = 1'b0;
        wait_done(found, cyc);
        n_cmp++;
        if (!found || got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("[TB] FAIL bp_count: %0d writes done %0d, required %0d and done",
                     got_q.size(), found, exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("[TB] FAIL bp_word%0d: got %h, required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_illegal();
        int w, cyc;
        bit found;
        start_stream();
        send(19, 1, 0, 0, 0, 0, 2048, 1'b0, w);
        n_cmp++;
        if (o_Error !== 1'b1 || o_WrValid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL illegal_imm: error %b valid %b, required 1 0", o_Error, o_WrValid);
        end
        send(99, 0, 0, 0, 0, 0, 3, 1'b0, w);
        send(55, 1, 0, 0, 0, 0, 0, 1'b0, w);
        n_cmp++;
        if (o_WrValid !== 1'b0 || got_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL illegal_nowrite: valid %b writes %0d, required 0 0", o_WrValid, got_q.size());
        end
        send(19, 2, 0, 0, 0, 0, 1, 1'b1, w);
        i_Valid = 1'b0;
        wait_done(found, cyc);
        n_cmp++;
        if (!found || got_q.size() != 1 || got_q[0] !== {32'h0, 32'h0010_0113}) begin
            n_fail++;
            $display("[TB] FAIL illegal_reuse: done %0d writes %0d first %h, required 1 1 0000000000100113",
                     found, got_q.size(), got_q.size() > 0 ? got_q[0] : 64'h0);
        end
        n_cmp++;
        if (o_Error !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL error_sticky: got %b, required 1", o_Error);
        end
        start_stream();
        n_cmp++;
        if (o_Error !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL error_clear: got %b, required 0", o_Error);
        end
        send(51, 3, 1, 2, 0, 32, 0, 1'b1, w);
        i_Valid = 1'b0;
        wait_done(found, cyc);
        n_cmp++;
        if (!found || got_q.size() != 1 || got_q[0] !== {32'h0, 32'h4020_81B3}) begin
            n_fail++;
            $display("[TB] FAIL rtype_word: done %0d writes %0d first %h, required 1 1 00000000402081b3",
                     found, got_q.size(), got_q.size() > 0 ? got_q[0] : 64'h0);
        end
    endtask

    task automatic test_reset_mid();
        int w;
        ready_force = 1'b0;
        @(posedge i_Clk);
        #2;
        start_stream();
        send(19, 4, 4, 0, 0, 0, 12, 1'b0, w);
        i_Valid = 1'b0;
        i_Reset = 1'b1;
        @(posedge i_Clk);
        #1 i_Reset = 1'b0;
        n_cmp++;
        if (o_WrValid !== 1'b0 || o_WrAddr !== 32'd0 || o_Ready !== 1'b0 || o_Error !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midreset_state: valid %b addr %h ready %b error %b, required 0 0 0 0",
                     o_WrValid, o_WrAddr, o_Ready, o_Error);
        end
        ready_force = 1'b1;
        i_Valid = 1'b1;
        i_OpCode = 7'd19;
        i_Imm = 32'd1;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_Clk);
            n_cmp++;
            if (o_Ready !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL midreset_ignore%0d: ready %b, required 0", i, o_Ready);
            end
        end
        i_Valid = 1'b0;
        @(negedge i_Clk);
        n_cmp++;
        if (got_q.size() != 0 || o_WrValid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midreset_nowrite: writes %0d valid %b, required 0 0", got_q.size(), o_WrValid);
        end
    endtask

    task automatic test_wrap();
        int w, cyc;
        bit found;
        start_stream();
        send(19, 1, 0, 0, 0, 0, 5, 1'b0, w);
        send(19, 2, 0, 0, 0, 0, 1, 1'b1, w);
        i_Valid = 1'b0;
        wait_done(found, cyc);
        n_cmp++;
        if (got2_q.size() != 2 || !found) begin
            n_fail++;
            $display("[TB] FAIL wrap_count: %0d writes done %0d, required 2 and done", got2_q.size(), found);
        end else begin
            n_cmp++;
            if (got2_q[0] !== {32'hFFFF_FFFC, 32'h0050_0093}) begin
                n_fail++;
                $display("[TB] FAIL wrap_first: got %h, required fffffffc00500093", got2_q[0]);
            end
            n_cmp++;
            if (got2_q[1] !== {32'h0000_0000, 32'h0010_0113}) begin
                n_fail++;
                $display("[TB] FAIL wrap_second: got %h, required 0000000000100113", got2_q[1]);
            end
        end
    endtask

    task automatic test_random();
        int ops[7];
        int w, cyc, n, op;
        bit found;
        ops[0] = 3; ops[1] = 19; ops[2] = 35; ops[3] = 51; ops[4] = 99; ops[5] = 111; ops[6] = 55;
        rand_ready = 1'b1;
        for (int s = 0; s < 8; s++) begin
            start_stream();
            n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) begin
                op = ops[$urandom_range(0, 6)];
                send(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 7), $urandom_range(0, 127), pick_imm(op), k == n - 1, w);
            end
            i_Valid = 1'b0;
            wait_done(found, cyc);
            n_cmp++;
            if (!found || got_q.size() != exp_q.size() || o_Error !== model_err) begin
                n_fail++;
                $display("[TB] FAIL rand%0d_summary: done %0d writes %0d error %b, required 1 %0d %b",
                         s, found, got_q.size(), o_Error, exp_q.size(), model_err);
            end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                n_cmp++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("[TB] FAIL rand%0d_word%0d: got %h, required %h", s, i, got_q[i], exp_q[i]);
                end
            end
        end
        rand_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_formats();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
